// File: rtl/spi_regfile_pkg.sv
// Shared constants, address map and FSM state type for the SPI register file.
package spi_regfile_pkg;

  localparam int FRAME_W  = 16;
  localparam int NUM_REGS = 5;

  localparam logic [4:0] FRAME_BITS = 5'(FRAME_W);
  localparam logic [4:0] CNT_SAT    = 5'd17;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDR         = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser bringing one pad signal into the clk domain.
module spi_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_regfile.sv
// Mode-0 SPI slave writing a five-entry register file, oversampled in the clk domain.
// Define SPI_READBACK_EN to add read frames returning register data on cipo.
module spi_regfile
  import spi_regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic ncsSync, sclkSync, copiSync;
  logic ncsPrev_q, sclkPrev_q;
  logic ncsFall, ncsRise, sclkRise;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           regs_q [NUM_REGS];
  logic [7:0]           regs_d [NUM_REGS];
  logic                 frameOk;

  spi_sync2 #(.RESET_VAL(1'b1)) uSyncNcs  (.clk(clk), .rst(rst), .d_i(ncs),  .q_o(ncsSync));
  spi_sync2 #(.RESET_VAL(1'b0)) uSyncSclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclkSync));
  spi_sync2 #(.RESET_VAL(1'b0)) uSyncCopi (.clk(clk), .rst(rst), .d_i(copi), .q_o(copiSync));

  assign ncsFall  = ncsPrev_q & ~ncsSync;
  assign ncsRise  = ~ncsPrev_q & ncsSync;
  assign sclkRise = sclkSync & ~sclkPrev_q;

  assign frameOk = (cnt_q == FRAME_BITS) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

  // A falling ncs seen while committing is remembered so back-to-back frames are not lost.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (ncsFall || pend_q) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (sclkRise) begin
          shift_d = {shift_q[FRAME_W-2:0], copiSync};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
        if (ncsRise) state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (frameOk && (shift_q[14:8] == 7'(i))) regs_d[i] = shift_q[7:0];
        end
        if (ncsFall) pend_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncsPrev_q  <= 1'b1;
      sclkPrev_q <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ncsPrev_q  <= ncsSync;
      sclkPrev_q <= sclkSync;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      regs_q     <= regs_d;
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclkFall;
  logic [6:0] rdAddr;
  logic [7:0] rd_q, rd_d;
  logic       rdValid_q, rdValid_d;
  logic       cipo_q, cipo_d;

  assign sclkFall = ~sclkSync & sclkPrev_q;
  assign rdAddr   = {shift_q[5:0], copiSync};

  // The 8th rising edge completes R/W plus address; data then leaves on falls 8..15.
  always_comb begin
    rd_d      = rd_q;
    rdValid_d = rdValid_q;
    cipo_d    = cipo_q;
    if (state_q != SHIFT) begin
      rdValid_d = 1'b0;
      cipo_d    = 1'b0;
    end else begin
      if (sclkRise && (cnt_q == 5'd7) && !shift_q[6] && (rdAddr <= MAX_ADDR)) begin
        rdValid_d = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rdAddr == 7'(i)) rd_d = regs_q[i];
        end
      end
      if (sclkFall) begin
        if (rdValid_q && (cnt_q >= 5'd8) && (cnt_q <= 5'd15)) begin
          cipo_d = rd_q[7];
          rd_d   = {rd_q[6:0], 1'b0};
        end else begin
          cipo_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= '0;
      rdValid_q <= 1'b0;
      cipo_q    <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      rdValid_q <= rdValid_d;
      cipo_q    <= cipo_d;
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];

endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  system clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI serial clock from a pad; asynchronous to clk.
- copi  input  1  SPI controller-out data from a pad; asynchronous to clk.
- ncs  input  1  SPI chip select from a pad; active-low; asynchronous to clk.
- cipo  output  1  SPI controller-in data; used only when SPI_READBACK_EN is defined.
- en_reg_out_7_0  output  8  output-enable bits for outputs 7..0 (PWM stage).
- en_reg_out_15_8  output  8  output-enable bits for outputs 15..8.
- en_reg_pwm_7_0  output  8  PWM-enable bits for outputs 7..0.
- en_reg_pwm_15_8  output  8  PWM-enable bits for outputs 15..8.
- pwm_duty_cycle  output  8  shared PWM duty cycle.
REQ-002 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst); these are fixed.
REQ-003 The block SHALL have no parameters; the frame width (16) and the register count (5) SHALL be package constants.

Function
REQ-004 The SPI link SHALL be mode 0: copi is sampled on the sclk rising edge, and cipo changes on the sclk falling edge.
REQ-005 Each of sclk, copi and ncs SHALL pass through a 2-flop synchroniser into clk; edges SHALL be detected on the synchronised signals.
REQ-006 The sclk frequency SHALL be at most clk/4; behaviour above that rate is unspecified.
REQ-007 A frame SHALL be 16 bits, MSB first, with fields:
- bit15: R/W, 1 = write, 0 = read.
- bits14:8: address.
- bits7:0: data.
REQ-008 The FSM states SHALL be IDLE, SHIFT and COMMIT.
- IDLE -> SHIFT when a synchronised ncs falling edge is detected; this clears the shift register and the bit counter.
REQ-009 In SHIFT, each synchronised sclk rising edge SHALL shift copi into the LSB and increment a 5-bit bit counter.
- The counter saturates at 17; a count of 17 marks the frame as overflowed.
REQ-010 SHIFT -> COMMIT on a synchronised ncs rising edge.
- COMMIT -> IDLE on the next clk cycle, unconditionally.
REQ-011 In COMMIT, a register SHALL be written only if all of these hold: bit count == 16, R/W = 1, address <= 0x04.
- Any other frame SHALL be discarded with no register change.
REQ-012 The address map SHALL be:
- 0x00 en_reg_out_7_0
- 0x01 en_reg_out_15_8
- 0x02 en_reg_pwm_7_0
- 0x03 en_reg_pwm_15_8
- 0x04 pwm_duty_cycle
REQ-013 Addresses 0x05-0x7F SHALL be ignored.
REQ-014 A written value SHALL appear on its output at the 4th rising clk edge after the ncs pad rises, and SHALL NOT appear earlier.
- Edges 1-2: synchroniser; edge 3: edge detect into COMMIT; edge 4: register write.
REQ-015 The outputs SHALL hold their values between writes; glitches on sclk or copi while ncs is high SHALL have no effect.
REQ-016 A synchronised ncs rising edge received in IDLE SHALL be ignored.
- A new ncs falling edge seen during COMMIT SHALL be taken on return to IDLE, so back-to-back frames separated by at least 4 clk cycles of ncs high are both accepted.

Reset
REQ-017 While rst is high, the block SHALL force these values asynchronously:
- all five register outputs = 0x00
- cipo = 0
- FSM = IDLE
- bit counter = 0
- shift register = 0
- synchroniser flops: ncs chain = 1, sclk and copi chains = 0
REQ-018 If rst is asserted mid-frame, the partial frame SHALL be discarded.
- After rst falls, a new frame SHALL be accepted only after a fresh ncs falling edge.

Configuration
REQ-019 Macro SPI_READBACK_EN defined: reads are supported.
- For a read frame (bit15 = 0, address <= 0x04), the addressed register is latched at the 8th sclk rising edge.
- Its data is then driven on cipo MSB first, one bit per sclk falling edge, during bits 7..0.
- cipo = 0 whenever ncs is high or the address is invalid.
REQ-020 Macro SPI_READBACK_EN undefined: cipo SHALL be tied to 0 and read frames SHALL be discarded; register behaviour is otherwise identical.

Structure
REQ-021 The shared package spi_regfile_pkg SHALL hold:
- frame width constant (16)
- the five address constants
- max valid address (0x04)
- the FSM state enum (IDLE, SHIFT, COMMIT)
REQ-022 There SHALL be one sub-module, spi_sync2: a 2-flop synchroniser with a reset-value parameter, instantiated three times.

Verification
REQ-023 Write 0x00F0: frame 0x80F0 -> en_reg_out_7_0 = 0xF0 at the 4th clk edge after ncs rises; all other outputs stay 0x00.
REQ-024 Write 0x847F (addr 0x04) -> pwm_duty_cycle = 0x7F.
- Then frame 0x8555 (addr 0x05) -> no output changes.
REQ-025 15-bit frame 0x0301 followed by ncs high -> no change.
- 17-bit frame -> no change.
- Read frame 0x0001 -> no change.
REQ-026 Assert rst after the 9th bit of frame 0x82AA -> all outputs 0x00 and no write.
- Next full frame 0x82AA -> en_reg_pwm_7_0 = 0xAA.
REQ-027 Back-to-back frames 0x8101 and 0x8302, ncs high for 4 clk cycles between them -> en_reg_out_15_8 = 0x01 and en_reg_pwm_15_8 = 0x02.
REQ-028 With SPI_READBACK_EN defined: after pwm_duty_cycle = 0x5A, read frame 0x0400 -> cipo shifts 0,1,0,1,1,0,1,0 on bits 7..0.
- With SPI_READBACK_EN undefined: cipo stays 0.
